// File: rtl/time_display_scanner.sv
// time_display_scanner: multiplexes a BCD mm:ss snapshot onto a 4-digit active-low
// seven-segment display with leading-zero blanking, colon dp and freeze blinking.
module time_display_scanner #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] time_spent,
    input  logic        freeze,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic [1:0]    idx, idx_n;
    logic [15:0]   snap, snap_n;
    logic [3:0]    nib;
    logic          phase, phase_n, tick, bterm, blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    // Outputs are registered from next-state values, so they only move on tick
    // or phase edges, and digit 0 decodes straight from the freshly captured word.
    assign tick    = cnt == CW'(SCAN_DIV - 1);
    assign bterm   = bcnt == BW'(BLINK_DIV - 1);
    assign idx_n   = tick ? idx + 2'd1 : idx;
    assign snap_n  = (tick && idx == 2'd3) ? time_spent : snap;
    assign phase_n = freeze ? phase ^ bterm : 1'b1;
    assign nib     = snap_n[4*idx_n +: 4];
    assign blank   = idx_n == 2'd3 && nib == 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            bcnt  <= '0;
            idx   <= 2'd3;
            snap  <= '0;
            phase <= 1'b1;
            an    <= 4'hF;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            bcnt  <= (!freeze || bterm) ? '0 : bcnt + 1'b1;
            idx   <= idx_n;
            snap  <= snap_n;
            phase <= phase_n;
            an    <= (!phase_n || blank) ? 4'hF : ~(4'b0001 << idx_n);
            seg   <= blank ? 7'h7F : seg7(nib);
            dp    <= idx_n != 2'd2;
        end
    end
endmodule
